// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios PIO slaves: register map, edge-type codes
// and a counter-width helper.
package nios_pio_pkg;

    // Register map (word addresses on the 2-bit slave address bus)
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_DIR     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Capture edge selection
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Width of a counter that must hold 0..cycles; at least 1 bit so a
    // bypassed debouncer still has a legal declaration.
    function automatic int cnt_width(input int cycles);
        return (cycles > 0) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/nios_pio_debounce_bit.sv
// One input pin: two-flop synchroniser followed by a stable-count debouncer.
// The debounced level only follows the synchronised pin once it has held a
// new value for DEBOUNCE_CYCLES consecutive cycles.
module nios_pio_debounce_bit
    import nios_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic debounced
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic sync_p0;
    logic sync_p1;

    // Synchroniser: bring the asynchronous pin into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= IDLE_LEVEL;
            sync_p1 <= IDLE_LEVEL;
        end else begin
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // No filtering: the debounced level tracks the synchroniser
            always_ff @(posedge clk) begin
                if (reset) begin
                    debounced <= IDLE_LEVEL;
                end else begin
                    debounced <= sync_p1;
                end
            end
        end else begin : g_debounce
            localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] count;

            // Count consecutive cycles of disagreement; any return to the
            // accepted level restarts the count from zero
            always_ff @(posedge clk) begin
                if (reset) begin
                    count     <= '0;
                    debounced <= IDLE_LEVEL;
                end else if (sync_p1 == debounced) begin
                    count     <= '0;
                end else if (count == LAST) begin
                    count     <= '0;
                    debounced <= sync_p1;
                end else begin
                    count     <= count + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/nios_system_keys_in.sv
// Avalon-MM input PIO for pushbuttons/switches: per-pin debounce, edge
// capture with write-1-to-clear, maskable level interrupt.
module nios_system_keys_in
    import nios_pio_pkg::*;
#(
    parameter int   WIDTH           = 4,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   EDGE_TYPE       = 1,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] debounced_d;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic             wr_en;

    // Only the low WIDTH bits of writedata carry register content
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_pin
            nios_pio_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .IDLE_LEVEL     (IDLE_LEVEL)
            ) u_debounce (
                .clk      (clk),
                .reset    (reset),
                .pin      (in_port[i]),
                .debounced(debounced[i])
            );
        end
    endgenerate

    assign wr_en = chipselect && !write_n;
    assign clr   = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // Edge select from the debounced level and its one-cycle-old copy
    always_comb begin
        edges = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edges = debounced & ~debounced_d;
            EDGE_FALL: edges = ~debounced & debounced_d;
            default:   edges = debounced ^ debounced_d;
        endcase
    end

    // Register file, capture and interrupt state; an edge beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            debounced_d <= {WIDTH{IDLE_LEVEL}};
            irqmask     <= '0;
            edgecap     <= '0;
            irq         <= 1'b0;
        end else begin
            debounced_d <= debounced;
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            edgecap <= edges | (edgecap & ~clr);
            irq     <= |(edgecap & irqmask);
        end
    end

    // Zero-latency read mux; unused upper bits read as zero
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = 32'(debounced);
            ADDR_IRQMASK: readdata = 32'(irqmask);
            ADDR_EDGECAP: readdata = 32'(edgecap);
            default:      readdata = '0;
        endcase
    end

endmodule
